// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the 8N1 UART core.
package uart_pkg;
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_SAMPLE = 8;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
endpackage

// File: rtl/uart_baud_div.sv
// Oversample tick generator: one-clock tick every cfg+1 clocks, restartable via clear.
module uart_baud_div (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic [7:0] cfg,
  output logic       tick
);
  logic [7:0] r_cnt;

  // >= keeps the counter from running the full 8-bit range if cfg shrinks mid-count
  assign tick = (r_cnt >= cfg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else if (clear || tick)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + 8'd1;
  end
endmodule

// File: rtl/uart_core.sv
// Full-duplex 8N1 UART: independent TX and RX state machines, 16x oversampled receive.
module uart_core
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rstb,
  input  logic [7:0] baudrate_cfg,
  input  logic       rx,
  output logic       tx,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       rx_valid,
  output logic [7:0] rx_data
);
  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] TICK_MID  = 4'(MID_SAMPLE - 1);
  localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);

  uart_state_t r_tx_state;
  logic [3:0]  r_tx_tcnt;
  logic [2:0]  r_tx_bit;
  logic [7:0]  r_tx_shift;
  logic        r_tx;
  logic        r_tx_busy;
  logic        w_tx_tick;
  logic        w_tx_bit_end;
  logic        w_tx_accept;

  uart_state_t r_rx_state;
  logic [3:0]  r_rx_tcnt;
  logic [2:0]  r_rx_bit;
  logic [7:0]  r_rx_shift;
  logic [7:0]  r_rx_data;
  logic        r_rx_valid;
  logic        r_rx_s1, r_rx_s2, r_rx_s3;
  logic        w_rx_tick;
  logic        w_rx_fall;
  logic        w_rx_clear;
  logic        w_rx_mid;
  logic        w_rx_bit_end;

  assign tx       = r_tx;
  assign tx_busy  = r_tx_busy;
  assign rx_valid = r_rx_valid;
  assign rx_data  = r_rx_data;

  // A request in the last cycle of the stop bit is taken directly, so frames can abut.
  assign w_tx_bit_end = w_tx_tick && (r_tx_tcnt == TICK_LAST);
  assign w_tx_accept  = tx_valid &&
                        ((r_tx_state == IDLE) || ((r_tx_state == STOP) && w_tx_bit_end));

  uart_baud_div u_tx_div (
    .clk   (clk),
    .rst   (rstb),
    .clear (w_tx_accept),
    .cfg   (baudrate_cfg),
    .tick  (w_tx_tick)
  );

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      r_tx_state <= IDLE;
      r_tx_tcnt  <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx       <= 1'b1;
      r_tx_busy  <= 1'b0;
    end else if (w_tx_accept) begin
      r_tx_state <= START;
      r_tx_tcnt  <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= tx_data;
      r_tx       <= 1'b0;
      r_tx_busy  <= 1'b1;
    end else begin
      if (w_tx_tick && (r_tx_state != IDLE))
        r_tx_tcnt <= r_tx_tcnt + 4'd1;
      case (r_tx_state)
        START: if (w_tx_bit_end) begin
          r_tx_state <= DATA;
          r_tx       <= r_tx_shift[0];
          r_tx_shift <= r_tx_shift >> 1;
        end
        DATA: if (w_tx_bit_end) begin
          if (r_tx_bit == BIT_LAST) begin
            r_tx_state <= STOP;
            r_tx       <= 1'b1;
          end else begin
            r_tx_bit   <= r_tx_bit + 3'd1;
            r_tx       <= r_tx_shift[0];
            r_tx_shift <= r_tx_shift >> 1;
          end
        end
        STOP: if (w_tx_bit_end) begin
          r_tx_state <= IDLE;
          r_tx_busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign w_rx_fall    = r_rx_s3 & ~r_rx_s2;
  assign w_rx_clear   = (r_rx_state == IDLE) && w_rx_fall;
  assign w_rx_mid     = w_rx_tick && (r_rx_tcnt == TICK_MID);
  assign w_rx_bit_end = w_rx_tick && (r_rx_tcnt == TICK_LAST);

  uart_baud_div u_rx_div (
    .clk   (clk),
    .rst   (rstb),
    .clear (w_rx_clear),
    .cfg   (baudrate_cfg),
    .tick  (w_rx_tick)
  );

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_s3    <= 1'b1;
      r_rx_state <= IDLE;
      r_rx_tcnt  <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_s1    <= rx;
      r_rx_s2    <= r_rx_s1;
      r_rx_s3    <= r_rx_s2;
      r_rx_valid <= 1'b0;
      if (w_rx_tick && (r_rx_state != IDLE))
        r_rx_tcnt <= r_rx_tcnt + 4'd1;
      case (r_rx_state)
        IDLE: if (w_rx_fall) begin
          r_rx_state <= START;
          r_rx_tcnt  <= '0;
        end
        // After the mid-start check, counting restarts so every later sample lands mid-bit.
        START: if (w_rx_mid) begin
          r_rx_tcnt <= '0;
          r_rx_bit  <= '0;
          r_rx_state <= r_rx_s2 ? IDLE : DATA;
        end
        DATA: if (w_rx_bit_end) begin
          r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
          if (r_rx_bit == BIT_LAST)
            r_rx_state <= STOP;
          else
            r_rx_bit <= r_rx_bit + 3'd1;
        end
        STOP: if (w_rx_bit_end) begin
          r_rx_state <= IDLE;
          if (r_rx_s2) begin
            r_rx_data  <= r_rx_shift;
            r_rx_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_core.sv
// Directed self-checking bench for uart_core: TX timing, loopback, glitch, framing error, reset.
module tb_uart_core;
  logic       clk = 1'b0;
  logic       rstb = 1'b1;
  logic [7:0] baudrate_cfg = 8'd0;
  logic       rx_drv = 1'b1;
  logic       loop_en = 1'b0;
  logic       rx;
  logic       tx;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'd0;
  logic       tx_busy;
  logic       rx_valid;
  logic [7:0] rx_data;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] rxq[$];
  int n_wide = 0;
  logic prev_v = 1'b0;

  assign rx = loop_en ? tx : rx_drv;
  always #5 clk = ~clk;

  uart_core dut (
    .clk          (clk),
    .rstb         (rstb),
    .baudrate_cfg (baudrate_cfg),
    .rx           (rx),
    .tx           (tx),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_busy      (tx_busy),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data)
  );

  always @(negedge clk) begin
    if (rx_valid) begin
      rxq.push_back(rx_data);
      if (prev_v) n_wide++;
    end
    prev_v = rx_valid;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] qget(input int i);
    if (rxq.size() > i) return rxq[i];
    return 8'hxx;
  endfunction

  task automatic send_tx(input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    while (tx_busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check_eq("tx_idle_wait", {31'd0, tx_busy}, 32'd0);
    tx_valid = 1'b1;
    tx_data  = d;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Bit-bang one frame on rx at 16 clocks per bit (baudrate_cfg = 0).
  task automatic drive_frame(input logic [7:0] d, input logic stopb);
    logic [9:0] f;
    f = {stopb, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = f[i];
      repeat (16) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  task automatic wait_rx(input int n, input int maxcyc);
    int c = 0;
    while (rxq.size() < n && c < maxcyc) begin
      @(negedge clk);
      c++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] frame;

    rstb = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_tx", {31'd0, tx}, 32'd1);
    check_eq("rst_busy", {31'd0, tx_busy}, 32'd0);
    check_eq("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check_eq("rst_rx_data", {24'd0, rx_data}, 32'h00);
    rstb = 1'b0;
    repeat (2) @(negedge clk);

    // TX 0xA5 at cfg=0: 16 clocks per bit, checked at first and last clock of each bit
    frame = {1'b1, 8'hA5, 1'b0};
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    check_eq("tx_busy_accept", {31'd0, tx_busy}, 32'd1);
    check_eq("tx_start_c0", {31'd0, tx}, 32'd0);
    for (int c = 1; c <= 160; c++) begin
      @(posedge clk); #1;
      if (c < 160 && (c % 16 == 0 || c % 16 == 15))
        check_eq($sformatf("tx_bit%0d_c%0d", c / 16, c), {31'd0, tx}, {31'd0, frame[c / 16]});
      if (c == 159) check_eq("tx_busy_c159", {31'd0, tx_busy}, 32'd1);
      if (c == 160) begin
        check_eq("tx_busy_c160", {31'd0, tx_busy}, 32'd0);
        check_eq("tx_idle_c160", {31'd0, tx}, 32'd1);
      end
    end
    @(negedge clk);

    // Loopback at cfg=6
    baudrate_cfg = 8'd6;
    loop_en = 1'b1;
    repeat (5) @(negedge clk);
    rxq.delete();
    n_wide = 0;
    send_tx(8'h00);
    send_tx(8'hFF);
    send_tx(8'h55);
    wait_rx(3, 4000);
    repeat (4) @(negedge clk);
    check_eq("loop_count", rxq.size(), 32'd3);
    check_eq("loop_b0", {24'd0, qget(0)}, 32'h00);
    check_eq("loop_b1", {24'd0, qget(1)}, 32'hFF);
    check_eq("loop_b2", {24'd0, qget(2)}, 32'h55);
    check_eq("loop_pulse_width", n_wide, 32'd0);

    // Start-bit glitch, then a good frame proves RX is back in IDLE
    loop_en = 1'b0;
    baudrate_cfg = 8'd0;
    repeat (40) @(negedge clk);
    rxq.delete();
    rx_drv = 1'b0;
    repeat (4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (200) @(negedge clk);
    check_eq("glitch_no_valid", rxq.size(), 32'd0);
    drive_frame(8'h96, 1'b1);
    wait_rx(1, 100);
    check_eq("after_glitch_count", rxq.size(), 32'd1);
    check_eq("after_glitch_byte", {24'd0, qget(0)}, 32'h96);

    // Framing error keeps prior rx_data
    rxq.delete();
    drive_frame(8'h3C, 1'b0);
    repeat (50) @(negedge clk);
    check_eq("frame_err_no_valid", rxq.size(), 32'd0);
    check_eq("frame_err_rx_data", {24'd0, rx_data}, 32'h96);
    drive_frame(8'hC3, 1'b1);
    wait_rx(1, 100);
    check_eq("after_ferr_byte", {24'd0, qget(0)}, 32'hC3);

    // Request while busy is dropped
    rxq.delete();
    loop_en = 1'b1;
    repeat (5) @(negedge clk);
    send_tx(8'h22);
    repeat (30) @(negedge clk);
    check_eq("busy_during_22", {31'd0, tx_busy}, 32'd1);
    tx_valid = 1'b1;
    tx_data  = 8'h11;
    @(negedge clk);
    tx_valid = 1'b0;
    wait_rx(1, 400);
    repeat (400) @(negedge clk);
    check_eq("ignore_count", rxq.size(), 32'd1);
    check_eq("ignore_byte", {24'd0, qget(0)}, 32'h22);
    check_eq("ignore_rx_data", {24'd0, rx_data}, 32'h22);

    // Asynchronous reset mid-frame
    send_tx(8'h5A);
    repeat (50) @(negedge clk);
    check_eq("pre_reset_busy", {31'd0, tx_busy}, 32'd1);
    #2 rstb = 1'b1;
    #1;
    check_eq("midrst_tx", {31'd0, tx}, 32'd1);
    check_eq("midrst_busy", {31'd0, tx_busy}, 32'd0);
    check_eq("midrst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check_eq("midrst_rx_data", {24'd0, rx_data}, 32'h00);
    @(negedge clk);
    rstb = 1'b0;
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
